data_ram_ctrl: RTL and testbench

Parametrised single-port data memory with a valid/ready request channel and a registered response channel. It supports byte-enable writes, bounds and alignment checks, and a post-reset sequential clear engine that replaces a bulk array reset. It sits between the core's load/store unit and the data address space, and serves as the next-generation data RAM.

---
 rtl/data_ram_ctrl.sv | 142 ++++++++++++++
 tb/tb_data_ram_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/data_ram_ctrl.sv
// Single-port data RAM with a valid/ready request channel, a registered one-cycle response and a post-reset clear engine.
// Optional soft clear is enabled with `define RAM_SOFT_CLEAR_EN, which adds the clear_req_i port.
module data_ram_ctrl #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 32,
    parameter int BYTE_ADDR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_be_i,
`ifdef RAM_SOFT_CLEAR_EN
    input  logic                clear_req_i,
`endif
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                busy_o
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH);
    localparam int OFF_W = (BYTE_ADDR != 0) ? $clog2(NB) : 0;
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(DEPTH - 1);

    typedef enum logic {INIT, IDLE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   clrCnt_q, clrCnt_d;
    logic               rspValid_q, rspValid_d;
    logic [DATA_W-1:0]  rspRdata_q, rspRdata_d;
    logic               rspErr_q, rspErr_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0]  idx;
    logic [CNT_W-1:0]   idxW;
    logic               reqErr;
    logic               accept;
    logic [DATA_W-1:0]  rdWord;
    logic [DATA_W-1:0]  merged;
    logic               memWe;
    logic [CNT_W-1:0]   memAddr;
    logic [DATA_W-1:0]  memWdata;

    // Range check uses the full-width index so high address bits can never alias onto a valid word.
    assign idx    = req_addr_i >> OFF_W;
    assign idxW   = idx[CNT_W-1:0];
    assign reqErr = (idx >= DEPTH_A) || ((req_addr_i & OFF_MASK) != '0);
    assign accept = (state_q == IDLE) && req_valid_i;
    assign rdWord = mem[idxW];

    always_comb begin
        merged = rdWord;
        for (int b = 0; b < NB; b++) begin
            if (req_be_i[b]) begin
                merged[b*8 +: 8] = req_wdata_i[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clrCnt_d   = clrCnt_q;
        rspValid_d = accept;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;
        memWe      = 1'b0;
        memAddr    = idxW;
        memWdata   = merged;

        case (state_q)
            INIT: begin
                memWe    = 1'b1;
                memAddr  = clrCnt_q;
                memWdata = '0;
                if (clrCnt_q == LAST_WORD) begin
                    state_d  = IDLE;
                    clrCnt_d = '0;
                end else begin
                    clrCnt_d = clrCnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (reqErr) begin
                        rspRdata_d = '0;
                        rspErr_d   = 1'b1;
                    end else begin
                        rspErr_d   = 1'b0;
                        rspRdata_d = req_we_i ? merged : rdWord;
                        memWe      = req_we_i;
                    end
                end
`ifdef RAM_SOFT_CLEAR_EN
                if (clear_req_i) begin
                    state_d  = INIT;
                    clrCnt_d = '0;
                end
`endif
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            clrCnt_q   <= '0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clrCnt_q   <= clrCnt_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end

    // The array has no reset; the clear engine zeroes it word by word instead.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= memWdata;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == INIT);
    assign rsp_valid_o = rspValid_q;
    assign rsp_rdata_o = rspRdata_q;
    assign rsp_err_o   = rspErr_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed self-checking bench for data_ram_ctrl (DEPTH=16, 32-bit words, byte addressing).
// Exercises the soft-clear path too when RAM_SOFT_CLEAR_EN is defined.
module tb_data_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
`ifdef RAM_SOFT_CLEAR_EN
    logic        clear_req;
`endif

    int errors = 0;
    int checks = 0;

    data_ram_ctrl #(
        .DATA_W(32), .DEPTH(16), .ADDR_W(32), .BYTE_ADDR(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
`ifdef RAM_SOFT_CLEAR_EN
        .clear_req_i (clear_req),
`endif
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request and clock it in; the response is then visible.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        tick();
    endtask

    task automatic idleCycle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        tick();
    endtask

    task automatic checkInitWindow(input string tag);
        int busyHits;
        busyHits = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy === 1'b1 && req_ready === 1'b0) busyHits++;
            tick();
        end
        checkOutput({tag, "_busy_cycles"}, 32'(busyHits), 32'd16);
        checkOutput({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_ready_done"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
`ifdef RAM_SOFT_CLEAR_EN
        clear_req = 1'b0;
`endif
        tick();
        tick();
        checkOutput("rst_busy", {31'd0, busy}, 32'd1);
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_err", {31'd0, rsp_err}, 32'd0);

        rst = 1'b0;
        checkInitWindow("init");

        applyStimulus(1'b0, 32'h3C, 32'h0, 4'h0);
        checkOutput("rd_last_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("rd_last_data", rsp_rdata, 32'h0);
        checkOutput("rd_last_err", {31'd0, rsp_err}, 32'd0);

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        checkOutput("wr_full_ack", rsp_rdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h10, 32'h11223344, 4'b0101);
        checkOutput("wr_be_merge", rsp_rdata, 32'hDE22BE44);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
        checkOutput("rd_after_merge", rsp_rdata, 32'hDE22BE44);
        applyStimulus(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
        checkOutput("wr_be0_data", rsp_rdata, 32'hDE22BE44);
        checkOutput("wr_be0_err", {31'd0, rsp_err}, 32'd0);
        idleCycle();
        checkOutput("idle_no_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("idle_hold_data", rsp_rdata, 32'hDE22BE44);

        applyStimulus(1'b1, 32'h8, 32'hA5A50001, 4'hF);
        checkOutput("b2b_0_valid", {31'd0, rsp_valid}, 32'd1);
        applyStimulus(1'b0, 32'h8, 32'h0, 4'h0);
        checkOutput("b2b_1_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("b2b_1_data", rsp_rdata, 32'hA5A50001);
        applyStimulus(1'b1, 32'hC, 32'h0BADF00D, 4'hF);
        checkOutput("b2b_2_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("b2b_2_data", rsp_rdata, 32'h0BADF00D);
        applyStimulus(1'b0, 32'hC, 32'h0, 4'h0);
        checkOutput("b2b_3_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("b2b_3_data", rsp_rdata, 32'h0BADF00D);
        idleCycle();
        checkOutput("b2b_end_valid", {31'd0, rsp_valid}, 32'd0);

        applyStimulus(1'b1, 32'h0, 32'hCAFE0000, 4'hF);
        applyStimulus(1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
        checkOutput("err_range_err", {31'd0, rsp_err}, 32'd1);
        checkOutput("err_range_data", rsp_rdata, 32'h0);
        applyStimulus(1'b0, 32'h42, 32'h0, 4'h0);
        checkOutput("err_align_err", {31'd0, rsp_err}, 32'd1);
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 4'hF);
        checkOutput("err_alias_err", {31'd0, rsp_err}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("err_word0_data", rsp_rdata, 32'hCAFE0000);
        checkOutput("err_word0_err", {31'd0, rsp_err}, 32'd0);
        idleCycle();

        applyStimulus(1'b0, 32'h8, 32'h0, 4'h0);
        checkOutput("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd1);
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        checkInitWindow("reinit");
        applyStimulus(1'b0, 32'h8, 32'h0, 4'h0);
        checkOutput("reinit_cleared", rsp_rdata, 32'h0);
        idleCycle();

`ifdef RAM_SOFT_CLEAR_EN
        clear_req = 1'b1;
        applyStimulus(1'b1, 32'h0, 32'h5, 4'hF);
        clear_req = 1'b0;
        req_valid = 1'b0;
        checkOutput("sc_ack_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("sc_ack_data", rsp_rdata, 32'h5);
        checkInitWindow("softclr");
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("sc_word0", rsp_rdata, 32'h0);
        idleCycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
